// File: rtl/spi_xip_pkg.sv
// Shared types and spi_top register map for the SPI execute-in-place bridge.
package spi_xip_pkg;

   typedef enum logic [3:0] {
      IDLE, PASS, TX1, DIV, SS, CTRL, POLL, RX0, CLR, RESP
   } state_t;

   localparam logic [4:0] REG_RX0     = 5'h00;
   localparam logic [4:0] REG_TX1     = 5'h04;
   localparam logic [4:0] REG_CTRL    = 5'h10;
   localparam logic [4:0] REG_DIVIDER = 5'h14;
   localparam logic [4:0] REG_SS      = 5'h18;

   localparam int CTRL_GO_BSY = 8;
   localparam int CHAR_LEN_W  = 7;
   localparam logic [CHAR_LEN_W-1:0] CHAR_LEN_64 = 7'd64;

   // Flash delivers the first byte in the top lane; the CPU expects it in the bottom lane.
   function automatic logic [31:0] byte_swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/spi_xip_wb_step.sv
// Single-operation Wishbone master: one start pulse produces one cycle ending in done.
module spi_xip_wb_step
   import spi_xip_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  adr,
   input  logic [31:0] dat,
   input  logic        we,
   input  logic [3:0]  sel,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [4:0]  wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every process reads the pre-edge value of this state.
      if (reset) begin
         done     <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
         wb_we_o  <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_cyc_o <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wb_cyc_o) begin
            if (wb_ack_i || wb_err_i) begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               done     <= 1'b1;
               err      <= wb_err_i;
               rdata    <= wb_dat_i;
            end
         end else if (start) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
            wb_we_o  <= we;
            wb_sel_o <= sel;
         end
      end
   end

endmodule

// File: rtl/spi_xip_bridge.sv
// APB front end for spi_top: XIP flash reads plus register pass-through.
// Optional one-word read cache is built when XIP_CACHE_EN is defined.
module spi_xip_bridge
   import spi_xip_pkg::*;
#(
   parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
   parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
   parameter logic [31:0] REG_BASE   = 32'h1000_1000,
   parameter logic [31:0] REG_END    = 32'h1000_1fff,
   parameter logic [7:0]  READ_CMD   = 8'h03,
   parameter logic [15:0] CLK_DIV    = 16'd1,
   parameter int          SS_IDX     = 0,
   parameter int          POLL_MAX   = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic [4:0]  wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int POLL_W = $clog2(POLL_MAX + 1);

   state_t            state;
   logic [23:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_strb;
   logic              req_write;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic [POLL_W-1:0] poll_cnt;
   logic              step_busy;
   logic              step_start;
   logic              step_done;
   logic              step_err;
   logic [31:0]       step_rdata;
   logic [4:0]        op_adr;
   logic [31:0]       op_dat;
   logic              op_we;
   logic [3:0]        op_sel;
   logic              hit_reg;
   logic              hit_flash;

   assign hit_reg   = (in_paddr >= REG_BASE)   && (in_paddr <= REG_END);
   assign hit_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);

`ifdef XIP_CACHE_EN
   logic        cache_valid;
   logic [21:0] cache_tag;
   logic [31:0] cache_data;
   logic        cache_hit;
   assign cache_hit = cache_valid && (cache_tag == in_paddr[23:2]);
`endif

   always_comb begin
      // NOTE: every op_* gets a default first so no state leaves one unassigned and infers a latch.
      op_adr = REG_RX0;
      op_dat = '0;
      op_we  = 1'b1;
      op_sel = 4'hf;
      case (state)
         PASS: begin
            op_adr = req_addr[4:0];
            op_dat = req_wdata;
            op_we  = req_write;
            op_sel = req_strb;
         end
         TX1: begin
            op_adr = REG_TX1;
            op_dat = {READ_CMD, req_addr[23:2], 2'b00};
         end
         DIV: begin
            op_adr = REG_DIVIDER;
            op_dat = {16'd0, CLK_DIV};
         end
         SS: begin
            op_adr = REG_SS;
            op_dat = 32'd1 << SS_IDX;
         end
         CTRL: begin
            op_adr                   = REG_CTRL;
            op_dat[CTRL_GO_BSY]      = 1'b1;
            op_dat[CHAR_LEN_W-1:0]   = CHAR_LEN_64;
         end
         POLL: begin
            op_adr = REG_CTRL;
            op_we  = 1'b0;
         end
         RX0: op_we = 1'b0;
         CLR: op_adr = REG_SS;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_wdata  <= '0;
         req_strb   <= '0;
         req_write  <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         poll_cnt   <= '0;
         step_busy  <= 1'b0;
         step_start <= 1'b0;
         in_pready  <= 1'b0;
         in_prdata  <= '0;
         in_pslverr <= 1'b0;
`ifdef XIP_CACHE_EN
         // NOTE: only the valid bit is reset; tag and data are meaningless while it is clear.
         cache_valid <= 1'b0;
`endif
      end else begin
         step_start <= 1'b0;
         case (state)
            IDLE: begin
               if (in_psel && in_penable) begin
                  req_addr  <= in_paddr[23:0];
                  req_wdata <= in_pwdata;
                  req_strb  <= in_pstrb;
                  req_write <= in_pwrite;
                  resp_data <= '0;
                  resp_err  <= 1'b0;
                  poll_cnt  <= '0;
                  if (hit_reg) begin
                     state <= PASS;
`ifdef XIP_CACHE_EN
                     if (in_pwrite) cache_valid <= 1'b0;
`endif
                  end else if (hit_flash && !in_pwrite) begin
`ifdef XIP_CACHE_EN
                     if (cache_hit) begin
                        state     <= RESP;
                        in_pready <= 1'b1;
                        in_prdata <= cache_data;
                     end else begin
                        state <= TX1;
                     end
`else
                     state <= TX1;
`endif
                  end else begin
                     state      <= RESP;
                     in_pready  <= 1'b1;
                     in_pslverr <= 1'b1;
                  end
               end
            end
            RESP: begin
               in_pready  <= 1'b0;
               in_pslverr <= 1'b0;
               in_prdata  <= '0;
               state      <= IDLE;
            end
            default: begin
               // Wishbone step states: launch once, then act on completion.
               if (!step_busy) begin
                  step_start <= 1'b1;
                  step_busy  <= 1'b1;
               end else if (step_done) begin
                  step_busy <= 1'b0;
                  if (state == PASS) begin
                     state      <= RESP;
                     in_pready  <= 1'b1;
                     in_prdata  <= step_rdata;
                     in_pslverr <= step_err;
                  end else if (state == CLR) begin
                     state      <= RESP;
                     in_pready  <= 1'b1;
                     in_prdata  <= resp_data;
                     in_pslverr <= resp_err;
`ifdef XIP_CACHE_EN
                     if (resp_err) cache_valid <= 1'b0;
`endif
                  end else if (step_err) begin
                     resp_err <= 1'b1;
                     state    <= CLR;
                  end else begin
                     case (state)
                        TX1:  state <= DIV;
                        DIV:  state <= SS;
                        SS:   state <= CTRL;
                        CTRL: state <= POLL;
                        POLL: begin
                           poll_cnt <= poll_cnt + 1'b1;
                           if (!step_rdata[CTRL_GO_BSY]) begin
                              state <= RX0;
                           end else if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
                              resp_err <= 1'b1;
                              state    <= CLR;
                           end
                        end
                        RX0: begin
                           resp_data <= byte_swap(step_rdata);
                           state     <= CLR;
`ifdef XIP_CACHE_EN
                           cache_valid <= 1'b1;
                           cache_tag   <= req_addr[23:2];
                           cache_data  <= byte_swap(step_rdata);
`endif
                        end
                        default: state <= IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   spi_xip_wb_step u_step (
      .clock    (clock),
      .reset    (reset),
      .start    (step_start),
      .adr      (op_adr),
      .dat      (op_dat),
      .we       (op_we),
      .sel      (op_sel),
      .done     (step_done),
      .err      (step_err),
      .rdata    (step_rdata),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_stb_o (wb_stb_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i)
   );

endmodule

// File: tb/tb_spi_xip_bridge.sv
// Directed bench for spi_xip_bridge with a behavioural spi_top Wishbone responder.
// Cache checks are compiled in when XIP_CACHE_EN is defined.
`timescale 1ns/1ps
module tb_spi_xip_bridge;
   import spi_xip_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_paddr = '0;
   logic        in_psel = 1'b0;
   logic        in_penable = 1'b0;
   logic        in_pwrite = 1'b0;
   logic [31:0] in_pwdata = '0;
   logic [3:0]  in_pstrb = '0;
   logic        in_pready;
   logic [31:0] in_prdata;
   logic        in_pslverr;
   logic [4:0]  wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   spi_xip_bridge dut (
      .clock(clock), .reset(reset),
      .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
      .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
      .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   // spi_top model: logs every op, answers one cycle later, scripts CTRL busy polls.
   logic [4:0]  log_adr [4096];
   logic [31:0] log_dat [4096];
   logic        log_we  [4096];
   logic [3:0]  log_sel [4096];
   int          log_n = 0;
   int          poll_seen = 0;
   int          poll_base = 0;
   int          busy_polls = 0;
   bit          busy_forever = 1'b0;
   bit          err_en = 1'b0;
   logic [4:0]  err_adr = '0;
   logic [31:0] rx0_val = '0;

   always @(posedge clock) begin
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
         if (log_n < 4096) begin
            log_adr[log_n] = wb_adr_o;
            log_dat[log_n] = wb_dat_o;
            log_we[log_n]  = wb_we_o;
            log_sel[log_n] = wb_sel_o;
         end
         log_n = log_n + 1;
         if (err_en && wb_adr_o == err_adr) wb_err_i <= 1'b1;
         else                               wb_ack_i <= 1'b1;
         if (!wb_we_o) begin
            if (wb_adr_o == 5'h10) begin
               if (busy_forever || (poll_seen - poll_base) < busy_polls) wb_dat_i <= 32'h0000_0140;
               else                                                    wb_dat_i <= 32'h0000_0040;
               poll_seen = poll_seen + 1;
            end else if (wb_adr_o == 5'h00) begin
               wb_dat_i <= rx0_val;
            end else begin
               wb_dat_i <= 32'hcafe_0000 | 32'(wb_adr_o);
            end
         end
      end else begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One APB transfer (setup + access); also checks the response pulse is one cycle wide.
   task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int cycles);
      @(negedge clock);
      in_paddr = addr; in_pwrite = wr; in_pwdata = wdata; in_pstrb = 4'hf;
      in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clock);
      in_penable = 1'b1;
      cycles = 0;
      while (cycles < 20000) begin
         @(negedge clock);
         cycles++;
         if (in_pready) break;
      end
      check("pready_seen", 32'(in_pready), 32'd1);
      rdata = in_prdata;
      err   = in_pslverr;
      in_psel = 1'b0; in_penable = 1'b0;
      @(negedge clock);
      check("pready_pulse", {in_prdata[30:0], in_pready}, 32'd0);
      check("pslverr_clear", 32'(in_pslverr), 32'd0);
   endtask

   logic [4:0]  exp_adr [9] = '{5'h04, 5'h14, 5'h18, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00, 5'h18};
   logic        exp_we  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] exp_dat [9] = '{32'h0300_0100, 32'd1, 32'd1, 32'h140, 0, 0, 0, 0, 32'd0};

   initial begin
      logic [31:0] rd;
      logic        er;
      int          cyc;
      int          base;
      int          guard;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_pready", 32'(in_pready), 32'd0);
      check("rst_prdata", in_prdata, 32'd0);
      check("rst_pslverr", 32'(in_pslverr), 32'd0);
      check("rst_wb_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
      check("rst_wb_adr_dat", wb_dat_o | 32'(wb_adr_o), 32'd0);
      reset = 1'b0;

      // PASS write to DIVIDER
      base = log_n;
      apb(32'h1000_1014, 1'b1, 32'h0000_0004, rd, er, cyc);
      check("pass_count", log_n - base, 1);
      check("pass_adr", 32'(log_adr[base]), 32'h14);
      check("pass_dat", log_dat[base], 32'h4);
      check("pass_we_sel", {log_we[base], log_sel[base]}, 32'h1f);
      check("pass_err", 32'(er), 32'd0);

      // Flash read with two busy polls
      base = log_n; poll_base = poll_seen; busy_polls = 2; rx0_val = 32'hefbe_adde;
      apb(32'h3000_0100, 1'b0, 32'd0, rd, er, cyc);
      check("fr_count", log_n - base, 9);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("fr_adr%0d", i), 32'(log_adr[base + i]), 32'(exp_adr[i]));
         check($sformatf("fr_we%0d", i), 32'(log_we[base + i]), 32'(exp_we[i]));
         if (exp_we[i]) check($sformatf("fr_dat%0d", i), log_dat[base + i], exp_dat[i]);
      end
      check("fr_data", rd, 32'hdead_beef);
      check("fr_err", 32'(er), 32'd0);
      busy_polls = 0;

      // Flash write is rejected without Wishbone traffic
      base = log_n;
      apb(32'h3000_0000, 1'b1, 32'h1234_5678, rd, er, cyc);
      check("fw_count", log_n - base, 0);
      check("fw_err", 32'(er), 32'd1);
      check("fw_latency", 32'(cyc <= 2), 32'd1);

      // Unmapped address
      base = log_n;
      apb(32'h2000_0000, 1'b0, 32'd0, rd, er, cyc);
      check("um_count", log_n - base, 0);
      check("um_err", 32'(er), 32'd1);

      // CTRL busy forever: exactly POLL_MAX polls, then SS cleared
      base = log_n; poll_base = poll_seen; busy_forever = 1'b1;
      apb(32'h3000_0300, 1'b0, 32'd0, rd, er, cyc);
      check("to_polls", poll_seen - poll_base, 1024);
      check("to_last_adr", 32'(log_adr[log_n - 1]), 32'h18);
      check("to_last_dat", log_dat[log_n - 1], 32'd0);
      check("to_prev_poll", 32'(log_adr[log_n - 2]), 32'h10);
      check("to_err", 32'(er), 32'd1);

      // Reset asserted while polling
      poll_base = poll_seen;
      @(negedge clock);
      in_paddr = 32'h3000_0100; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
      @(negedge clock);
      in_penable = 1'b1;
      guard = 0;
      while ((poll_seen - poll_base) < 3 && guard < 2000) begin
         @(negedge clock);
         guard++;
      end
      check("rp_polling", 32'((poll_seen - poll_base) >= 3), 32'd1);
      reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0;
      @(negedge clock);
      check("rp_apb_out", {in_prdata[29:0], in_pready, in_pslverr}, 32'd0);
      check("rp_wb_out", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}, 32'd0);
      check("rp_wb_dat", wb_dat_o, 32'd0);
      check("rp_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0; busy_forever = 1'b0;
      repeat (2) @(negedge clock);

      // Normal read after reset
      base = log_n; rx0_val = 32'hefbe_adde;
      apb(32'h3000_0100, 1'b0, 32'd0, rd, er, cyc);
      check("ar_count", log_n - base, 7);
      check("ar_data", rd, 32'hdead_beef);
      check("ar_err", 32'(er), 32'd0);

      // Low address bits ignored; byte order corrected
      base = log_n; rx0_val = 32'h4433_2211;
      apb(32'h3000_0206, 1'b0, 32'd0, rd, er, cyc);
      check("al_tx1", log_dat[base], 32'h0300_0204);
      check("al_data", rd, 32'h1122_3344);

      // Wishbone error on DIVIDER write skips to CLR
      base = log_n; err_en = 1'b1; err_adr = 5'h14;
      apb(32'h3000_0400, 1'b0, 32'd0, rd, er, cyc);
      err_en = 1'b0;
      check("we_count", log_n - base, 3);
      check("we_last_adr", 32'(log_adr[log_n - 1]), 32'h18);
      check("we_last_dat", log_dat[log_n - 1], 32'd0);
      check("we_err", 32'(er), 32'd1);

`ifdef XIP_CACHE_EN
      // Cache hit, then invalidation by a PASS write
      base = log_n; rx0_val = 32'hefbe_adde;
      apb(32'h3000_0100, 1'b0, 32'd0, rd, er, cyc);
      check("c1_count", log_n - base, 7);
      check("c1_data", rd, 32'hdead_beef);
      base = log_n; rx0_val = 32'h0403_0201;
      apb(32'h3000_0100, 1'b0, 32'd0, rd, er, cyc);
      check("c2_count", log_n - base, 0);
      check("c2_data", rd, 32'hdead_beef);
      check("c2_latency", 32'(cyc <= 2), 32'd1);
      apb(32'h1000_1014, 1'b1, 32'h0000_0004, rd, er, cyc);
      base = log_n;
      apb(32'h3000_0100, 1'b0, 32'd0, rd, er, cyc);
      check("c3_count", log_n - base, 7);
      check("c3_data", rd, 32'h0102_0304);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
